// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Multiplies with radix-2 shift-add and divides with restoring division,
// one bit per clock. Divide-by-zero and signed overflow finish immediately.
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       funct,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Out
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   localparam logic [2:0] F_MUL    = 3'b000;
   localparam logic [2:0] F_MULH   = 3'b001;
   localparam logic [2:0] F_MULHSU = 3'b010;
   localparam logic [2:0] F_DIV    = 3'b100;
   localparam logic [2:0] F_REM    = 3'b110;

   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2:0]           funct_q, funct_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     opnd_q, opnd_d;
   logic                 negRes_q, negRes_d;
   logic                 negRem_q, negRem_d;
   logic [WIDTH-1:0]     out_q, out_d;
   logic                 outValid_q, outValid_d;

   logic                 aSigned, bSigned;
   logic                 aNeg, bNeg;
   logic [WIDTH-1:0]     absA, absB;
   logic                 isDivide;
   logic                 divByZero, divOverflow, fastPath;
   logic [WIDTH-1:0]     fastResult;

   logic [WIDTH:0]       mulSum;
   logic [2*WIDTH-1:0]   mulStep;
   logic [WIDTH:0]       shiftedRem;
   logic [WIDTH:0]       trialDiff;
   logic [2*WIDTH-1:0]   divStep;
   logic [2*WIDTH-1:0]   stepAcc;
   logic [2*WIDTH-1:0]   product;
   logic [WIDTH-1:0]     quotient, remainder;
   logic [WIDTH-1:0]     finalResult;
   logic                 lastIter;

   assign in_ready  = (state_q == IDLE);
   assign out_valid = outValid_q;
   assign Out       = out_q;

   // Operand conditioning at acceptance: decide which operands are signed,
   // take magnitudes, and detect the divide cases that need no iteration.
   always_comb begin
      aSigned     = (funct == F_MULH) || (funct == F_MULHSU) ||
                    (funct == F_DIV)  || (funct == F_REM);
      bSigned     = (funct == F_MULH) || (funct == F_DIV) || (funct == F_REM);
      aNeg        = aSigned & A[WIDTH-1];
      bNeg        = bSigned & B[WIDTH-1];
      absA        = aNeg ? -A : A;
      absB        = bNeg ? -B : B;
      isDivide    = funct[2];
      divByZero   = isDivide && (B == ZERO);
      divOverflow = isDivide && !funct[0] && (A == MIN_NEG) && (B == ALL_ONES);
      fastPath    = divByZero || divOverflow;
      fastResult  = ZERO;
      if (divByZero) begin
         fastResult = funct[1] ? A : ALL_ONES;
      end else if (divOverflow) begin
         fastResult = funct[1] ? ZERO : MIN_NEG;
      end
   end

   // One iteration of either datapath plus the sign-corrected result that
   // is written out when the last iteration completes.
   always_comb begin
      mulSum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
      mulStep     = acc_q[0] ? {mulSum, acc_q[WIDTH-1:1]}
                             : {1'b0, acc_q[2*WIDTH-1:1]};
      shiftedRem  = acc_q[2*WIDTH-1:WIDTH-1];
      trialDiff   = shiftedRem - {1'b0, opnd_q};
      divStep     = trialDiff[WIDTH]
                    ? {shiftedRem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                    : {trialDiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      stepAcc     = funct_q[2] ? divStep : mulStep;
      product     = negRes_q ? -stepAcc : stepAcc;
      quotient    = negRes_q ? -stepAcc[WIDTH-1:0] : stepAcc[WIDTH-1:0];
      remainder   = negRem_q ? -stepAcc[2*WIDTH-1:WIDTH]
                             : stepAcc[2*WIDTH-1:WIDTH];
      if (funct_q[2]) begin
         finalResult = funct_q[1] ? remainder : quotient;
      end else begin
         finalResult = (funct_q == F_MUL) ? product[WIDTH-1:0]
                                          : product[2*WIDTH-1:WIDTH];
      end
      lastIter    = (cnt_q == CNT_W'(WIDTH - 1));
   end

   // Control: accept in IDLE, iterate in BUSY, hold the result in DONE.
   // flush beats both acceptance and the output handshake.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      funct_d    = funct_q;
      acc_d      = acc_q;
      opnd_d     = opnd_q;
      negRes_d   = negRes_q;
      negRem_d   = negRem_q;
      out_d      = out_q;
      outValid_d = outValid_q;
      case (state_q)
         IDLE: begin
            if (in_valid && !flush) begin
               funct_d = funct;
               cnt_d   = '0;
               if (fastPath) begin
                  out_d      = fastResult;
                  outValid_d = 1'b1;
                  state_d    = DONE;
               end else begin
                  state_d  = BUSY;
                  negRes_d = aNeg ^ bNeg;
                  negRem_d = aNeg;
                  if (isDivide) begin
                     acc_d  = {ZERO, absA};
                     opnd_d = absB;
                  end else begin
                     acc_d  = {ZERO, absB};
                     opnd_d = absA;
                  end
               end
            end
         end
         BUSY: begin
            if (flush) begin
               state_d    = IDLE;
               outValid_d = 1'b0;
            end else begin
               acc_d = stepAcc;
               cnt_d = cnt_q + CNT_W'(1);
               if (lastIter) begin
                  out_d      = finalResult;
                  outValid_d = 1'b1;
                  state_d    = DONE;
               end
            end
         end
         DONE: begin
            if (flush || out_ready) begin
               state_d    = IDLE;
               outValid_d = 1'b0;
            end
         end
         default: begin
            state_d    = IDLE;
            outValid_d = 1'b0;
         end
      endcase
   end

   // State and datapath registers, cleared asynchronously by Reset.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         funct_q    <= '0;
         acc_q      <= '0;
         opnd_q     <= '0;
         negRes_q   <= 1'b0;
         negRem_q   <= 1'b0;
         out_q      <= '0;
         outValid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         funct_q    <= funct_d;
         acc_q      <= acc_d;
         opnd_q     <= opnd_d;
         negRes_q   <= negRes_d;
         negRem_q   <= negRem_d;
         out_q      <= out_d;
         outValid_q <= outValid_d;
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard testbench for mul_div_unit: the driver pushes hand-computed
// results as operations are accepted, a forked monitor pops and compares
// whenever a result is handed over.
module tb_mul_div_unit;

   localparam int W = 32;

   logic          Clock = 1'b0;
   logic          Reset;
   logic [W-1:0]  A, B;
   logic [2:0]    funct;
   logic          in_valid, in_ready, flush;
   logic          out_valid, out_ready;
   logic [W-1:0]  Out;

   int            tests = 0;
   int            failures = 0;
   logic [W-1:0]  expQ[$];
   string         nameQ[$];

   mul_div_unit #(.WIDTH(W)) dut (
      .Clock(Clock), .Reset(Reset), .A(A), .B(B), .funct(funct),
      .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .Out(Out)
   );

   // Free-running clock, period 10.
   always #5 Clock = ~Clock;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Compares every result taken by the consumer against the queue head.
   task automatic monitor();
      logic [W-1:0] e;
      string        n;
      forever begin
         @(negedge Clock);
         if (!Reset && out_valid && out_ready && !flush) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpectedResult", Out, 32'h0);
               if (Out === 32'h0) begin
                  failures++;
                  $display("[TB] FAIL unexpectedResult: got a result, expected none");
               end
            end else begin
               e = expQ.pop_front();
               n = nameQ.pop_front();
               checkOutput(n, Out, e);
            end
         end
      end
   endtask

   // Issues one op from IDLE (called #1 after a rising edge) and returns once
   // out_valid is seen. Inputs are scrambled while the unit works.
   // expLat counts rising edges after the accepting edge.
   task automatic applyStimulus(input string name, input logic [2:0] f,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] expected, input int expLat,
                                input bit push);
      int n;
      bit readyLow;
      A = a; B = b; funct = f; in_valid = 1'b1;
      if (push) begin
         expQ.push_back(expected);
         nameQ.push_back(name);
      end
      @(posedge Clock); #1;
      n = 0;
      readyLow = (in_ready === 1'b0);
      while (out_valid !== 1'b1 && n < 100) begin
         A = $urandom; B = $urandom; funct = 3'($urandom_range(0, 7));
         in_valid = 1'($urandom_range(0, 1));
         @(posedge Clock); #1;
         n++;
         if (in_ready !== 1'b0) readyLow = 1'b0;
      end
      in_valid = 1'b0;
      checkOutput({name, " outValid"}, {31'b0, out_valid}, 32'd1);
      checkOutput({name, " latency"}, n, expLat);
      checkOutput({name, " inReadyLow"}, {31'b0, readyLow}, 32'd1);
   endtask

   // Full operation with an immediate handshake, then the return to IDLE.
   task automatic runOp(input string name, input logic [2:0] f,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] expected, input int expLat);
      applyStimulus(name, f, a, b, expected, expLat, 1'b1);
      @(posedge Clock); #1;
      checkOutput({name, " inReadyAfter"}, {31'b0, in_ready}, 32'd1);
      checkOutput({name, " validCleared"}, {31'b0, out_valid}, 32'd0);
   endtask

   // Starts an op that will be aborted, so nothing is expected from it.
   task automatic startOp(input logic [2:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b);
      A = a; B = b; funct = f; in_valid = 1'b1;
      @(posedge Clock); #1;
      in_valid = 1'b0;
   endtask

   // Watches for a result that must not appear.
   task automatic expectSilence(input string name, input int cycles);
      bit seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge Clock); #1;
         if (out_valid !== 1'b0) seen = 1'b1;
      end
      checkOutput(name, {31'b0, seen}, 32'd0);
   endtask

   initial begin
      Reset = 1'b1; A = '0; B = '0; funct = '0;
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      fork
         monitor();
      join_none
      repeat (3) @(posedge Clock);
      #1 Reset = 1'b0;
      #1;
      checkOutput("reset outValid", {31'b0, out_valid}, 32'd0);
      checkOutput("reset Out", Out, 32'h0);
      checkOutput("reset inReady", {31'b0, in_ready}, 32'd1);
      @(posedge Clock); #1;

      // Multiplies
      runOp("MUL 7*-3",        3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 32);
      runOp("MULH min*min",    3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 32);
      runOp("MULHU max*max",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32);
      runOp("MULHSU -1*max",   3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32);
      runOp("MULH -1*1",       3'b001, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32);

      // Divides of -7 by 2
      runOp("DIV -7/2",        3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32);
      runOp("REM -7%2",        3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32);
      runOp("DIVU big/2",      3'b101, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32);
      runOp("REMU big%2",      3'b111, 32'hFFFFFFF9, 32'd2, 32'h00000001, 32);

      // Fast path and its unsigned counterparts that must iterate
      runOp("DIV 5/0",         3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 0);
      runOp("REMU 5%0",        3'b111, 32'd5,        32'd0,        32'd5,        0);
      runOp("DIV ovf",         3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
      runOp("REM ovf",         3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0);
      runOp("DIVU min/max",    3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32);
      runOp("REMU min%max",    3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32);

      // Backpressure: the result must hold for 10 cycles
      out_ready = 1'b0;
      applyStimulus("DIVU 100/7", 3'b101, 32'd100, 32'd7, 32'd14, 32, 1'b1);
      for (int i = 1; i <= 10; i++) begin
         @(posedge Clock); #1;
         checkOutput($sformatf("hold Out c%0d", i), Out, 32'd14);
         checkOutput($sformatf("hold valid c%0d", i), {31'b0, out_valid}, 32'd1);
      end
      out_ready = 1'b1;
      @(posedge Clock); #1;
      checkOutput("backpressure inReadyAfter", {31'b0, in_ready}, 32'd1);
      checkOutput("backpressure validCleared", {31'b0, out_valid}, 32'd0);

      // flush with in_valid in IDLE accepts nothing
      A = 32'd9; B = 32'd0; funct = 3'b100; in_valid = 1'b1; flush = 1'b1;
      @(posedge Clock); #1;
      in_valid = 1'b0; flush = 1'b0;
      checkOutput("idleFlush inReady", {31'b0, in_ready}, 32'd1);
      expectSilence("idleFlush noResult", 3);

      // flush at iteration 10 of a multiply
      startOp(3'b000, 32'd3, 32'd5);
      repeat (9) @(posedge Clock);
      #1 flush = 1'b1;
      @(posedge Clock); #1;
      flush = 1'b0;
      checkOutput("busyFlush inReady", {31'b0, in_ready}, 32'd1);
      expectSilence("busyFlush noResult", 40);
      runOp("MUL 3*5 afterFlush", 3'b000, 32'd3, 32'd5, 32'd15, 32);

      // flush in DONE beats a simultaneous handshake; Out is kept
      out_ready = 1'b0;
      applyStimulus("DIV 100/-7", 3'b100, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32, 1'b0);
      checkOutput("DIV 100/-7 Out", Out, 32'hFFFFFFF2);
      out_ready = 1'b1; flush = 1'b1;
      @(posedge Clock); #1;
      flush = 1'b0;
      checkOutput("doneFlush valid", {31'b0, out_valid}, 32'd0);
      checkOutput("doneFlush OutKept", Out, 32'hFFFFFFF2);
      checkOutput("doneFlush inReady", {31'b0, in_ready}, 32'd1);

      // Asynchronous reset in the middle of a multiply
      startOp(3'b000, 32'd3, 32'd5);
      repeat (10) @(posedge Clock);
      #3 Reset = 1'b1;
      #1;
      checkOutput("asyncReset valid", {31'b0, out_valid}, 32'd0);
      checkOutput("asyncReset Out", Out, 32'h0);
      checkOutput("asyncReset inReady", {31'b0, in_ready}, 32'd1);
      @(posedge Clock); #1;
      Reset = 1'b0;
      expectSilence("asyncReset noResult", 40);
      runOp("MUL 3*5 afterReset", 3'b000, 32'd3, 32'd5, 32'd15, 32);

      repeat (3) @(posedge Clock);
      #1;
      checkOutput("scoreboard drained", expQ.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
